// File: rtl/fetch_pkg.sv
// fetch_pkg -- definitions shared by the instruction fetch unit.
//   fetch_state_e    : base fetch FSM states (REQ -> RESP -> HOLD)
//   NOP_INSTR        : word shown on instr while in reset (addi x0,x0,0)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   PC_STEP          : byte increment between sequential fetches
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // issue a read when the response has somewhere to land
    ST_RESP = 2'd1,  // read data is on mem_rdata this cycle
    ST_HOLD = 2'd2   // output word waiting for the consumer
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf -- one-entry holding buffer for a fetched word and its pc.
// Catches a read response that arrives while the fetch output register is
// still waiting for the consumer.
// Ports:
//   clk          : clock
//   reset_i      : synchronous active-high reset, empties the buffer
//   flush_i      : drop the stored entry (fetch redirect)
//   push_i       : store push_instr_i / push_pc_i
//   push_instr_i : instruction word to store
//   push_pc_i    : byte address of that word
//   pop_i        : entry consumed this cycle
//   valid_o      : buffer holds an entry
//   instr_o      : stored instruction word
//   pc_o         : stored byte address
// A push and a pop in the same cycle replace the entry (stays valid).
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_instr_i,
  input  logic [31:0] push_pc_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (push_i) begin
      valid_d = 1'b1;
      instr_d = push_instr_i;
      pc_d    = push_pc_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
    // Flush wins over a simultaneous push.
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch with redirect support.
// Issues word reads to a memory with one-cycle read latency and presents
// each returned word with its address on a valid/ready output.
// Configuration macro: FETCH_SKID_EN
//   undefined : three-state FSM, one outstanding read, one word per 2 cycles
//   defined   : reads issue back to back while the output register plus a
//               one-entry skid buffer (fetch_skid_buf) can absorb them,
//               giving one word per cycle
// Parameter:
//   RESET_PC       : word-aligned first fetch address after reset
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high reset
//   mem_addr       : byte address of the read request (bits [1:0] = 0)
//   mem_rstrb      : read strobe; data returns on mem_rdata next cycle
//   mem_rdata      : read data
//   redirect_valid : restart fetch at redirect_pc (highest priority)
//   redirect_pc    : new fetch address, bits [1:0] ignored
//   instr_valid    : instr / instr_pc hold a fetched word
//   instr_ready    : consumer takes the word when instr_valid & instr_ready
//   instr          : fetched instruction word
//   instr_pc       : byte address instr came from
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;   // address of the read now in flight
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic accept;        // consumer takes the output word this cycle
  logic issue;         // read request this cycle
  logic resp_arrive;   // mem_rdata carries a response to keep this cycle

  assign accept = out_valid_q & instr_ready;

`ifdef FETCH_SKID_EN
  logic        inflight_q;
  logic        skid_valid;
  logic        skid_push;
  logic        skid_pop;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [1:0]  occupancy;

  // Words that will be held after this edge if nothing is issued now:
  // output + skid + the response currently arriving, minus what the
  // consumer takes. Issue only if that leaves a slot for one more word,
  // assuming the consumer might not accept next cycle.
  assign occupancy   = 2'(out_valid_q) + 2'(skid_valid) + 2'(inflight_q)
                       - 2'(accept);
  assign issue       = ~reset & ~redirect_valid & (occupancy <= 2'd1);
  assign resp_arrive = inflight_q & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
    end
  end

  fetch_skid_buf u_skid (
    .clk          (clk),
    .reset_i      (reset),
    .flush_i      (redirect_valid),
    .push_i       (skid_push),
    .push_instr_i (mem_rdata),
    .push_pc_i    (req_pc_q),
    .pop_i        (skid_pop),
    .valid_o      (skid_valid),
    .instr_o      (skid_instr),
    .pc_o         (skid_pc)
  );
`else
  fetch_state_e state_q, state_d;

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    resp_arrive = 1'b0;
    case (state_q)
      ST_REQ: begin
        // The response lands next cycle, so the output must be empty
        // then: either empty now or being accepted now.
        if (!out_valid_q || accept) begin
          issue   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RESP: begin
        resp_arrive = 1'b1;
        state_d     = ST_REQ;
      end
      ST_HOLD: begin
        if (accept) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
    if (redirect_valid) begin
      issue       = 1'b0;
      resp_arrive = 1'b0;
      state_d     = ST_REQ;
    end
    if (reset) begin
      issue = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  // Fetch pc and output register next state.
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q & ~accept;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
`ifdef FETCH_SKID_EN
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
`endif
    if (issue) begin
      pc_d     = pc_q + PC_STEP;   // wraps from FFFF_FFFC to 0
      req_pc_d = pc_q;
    end
`ifdef FETCH_SKID_EN
    if (!out_valid_q || accept) begin
      // Output slot frees up: the older skid word goes first to keep order.
      if (skid_valid) begin
        out_valid_d = 1'b1;
        out_instr_d = skid_instr;
        out_pc_d    = skid_pc;
        skid_pop    = 1'b1;
        skid_push   = resp_arrive;
      end else if (resp_arrive) begin
        out_valid_d = 1'b1;
        out_instr_d = mem_rdata;
        out_pc_d    = req_pc_q;
      end
    end else begin
      skid_push = resp_arrive;
    end
`else
    if (resp_arrive) begin
      out_valid_d = 1'b1;
      out_instr_d = mem_rdata;
      out_pc_d    = req_pc_q;
    end
`endif
    if (redirect_valid) begin
      pc_d        = redirect_pc & ~32'h3;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign mem_addr  = pc_q & ~32'h3;
  assign mem_rstrb = issue;
  // Outputs show their reset values for the whole reset cycle, not only
  // from the edge after it.
  assign instr_valid = out_valid_q & ~reset;
  assign instr       = reset ? NOP_INSTR : out_instr_q;
  assign instr_pc    = reset ? 32'h0 : out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit.
// Memory model: each word's content is a fixed function of its address,
// returned one cycle after a strobe; a marker value is driven otherwise.
// A per-cycle vector table covers start-up, stalls, redirects, wrap and
// reset; a hand-written sequence checks first-valid latency and throughput.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rstrb      (mem_rstrb),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a & ~32'h3) ^ 32'h5A5A_A5A3;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= mem_rstrb ? memword(mem_addr) : 32'hBAD0_BAD0;
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_rstrb;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rdy, input logic rv,
                     input logic [31:0] rpc, input logic e_rstrb,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_rstrb = e_rstrb; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_cycles;
    int nvalid;
    logic [31:0] exp_pc;
    logic exp_v;

`ifdef FETCH_SKID_EN
    //  rst rdy rv rpc            rstrb addr          valid pc
    add(1, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h4,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h8,           1, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'hC,           1, 32'h4);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'h8);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'h8);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'h8);
    add(0, 1, 0, 32'h0,           1, 32'h10,          1, 32'h8);
    add(0, 1, 0, 32'h0,           1, 32'h14,          1, 32'hC);
    add(0, 1, 0, 32'h0,           1, 32'h18,          1, 32'h10);
    add(0, 1, 1, 32'h42,          0, 32'h0,           1, 32'h14);
    add(0, 1, 0, 32'h0,           1, 32'h40,          0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h44,          0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h48,          1, 32'h40);
`else
    //  rst rdy rv rpc            rstrb addr          valid pc
    add(1, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h4,           1, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h8,           1, 32'h4);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'hC,           1, 32'h8);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    // consumer stalls five cycles: word 12 frozen, no reads
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'hC);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'hC);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'hC);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'hC);
    add(0, 0, 0, 32'h0,           0, 32'h0,           1, 32'hC);
    add(0, 1, 0, 32'h0,           0, 32'h0,           1, 32'hC);
    add(0, 1, 0, 32'h0,           1, 32'h10,          0, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h14,          1, 32'h10);
    // redirect while the read of 0x14 is returning: it is dropped
    add(0, 1, 1, 32'h42,          0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h40,          0, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h44,          1, 32'h40);
    // redirect to top of memory, low bits set: wrap to 0
    add(0, 1, 1, 32'hFFFF_FFFF,   0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'hFFFF_FFFC,   0, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h0,           1, 32'hFFFF_FFFC);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    // redirect alongside an accepted word, then back-to-back redirects
    add(0, 1, 1, 32'h100,         0, 32'h0,           1, 32'h0);
    add(0, 1, 1, 32'h200,         0, 32'h0,           0, 32'h0);
    add(0, 1, 1, 32'h300,         0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h300,         0, 32'h0);
    // reset while the read of 0x300 is returning
    add(1, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h4,           1, 32'h0);
    add(0, 1, 0, 32'h0,           0, 32'h0,           0, 32'h0);
    add(0, 1, 0, 32'h0,           1, 32'h8,           1, 32'h4);
`endif

    reset          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d mem_rstrb", i), 32'(mem_rstrb), 32'(vecs[i].e_rstrb));
      if (vecs[i].e_rstrb)
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      if (vecs[i].rst) begin
        chk($sformatf("v%0d reset instr_pc", i), instr_pc, 32'h0);
        chk($sformatf("v%0d reset instr", i), instr, NOP);
      end else if (vecs[i].e_valid) begin
        chk($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_pc);
        chk($sformatf("v%0d instr", i), instr, memword(vecs[i].e_pc));
      end
      $display("vec %0d: rst=%0d rdy=%0d rv=%0d rstrb=%0d addr=%h valid=%0d pc=%h instr=%h",
               i, reset, instr_ready, redirect_valid, mem_rstrb, mem_addr,
               instr_valid, instr_pc, instr);
    end

    // Fresh reset, then first-valid latency and 10-cycle throughput.
    @(negedge clk);
    reset          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    wait_cycles = 0;
    while (!instr_valid && wait_cycles < 8) begin
      @(negedge clk);
      #1;
      wait_cycles++;
    end
    chk("first_valid_latency", 32'(wait_cycles), 32'd2);
    $display("seq latency: first instr_valid after %0d cycles", wait_cycles);

    nvalid = 0;
    exp_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
`ifdef FETCH_SKID_EN
      exp_v = 1'b1;
`else
      exp_v = (i % 2) == 0;
`endif
      chk($sformatf("tput%0d instr_valid", i), 32'(instr_valid), 32'(exp_v));
      if (instr_valid) begin
        nvalid++;
        chk($sformatf("tput%0d instr_pc", i), instr_pc, exp_pc);
        chk($sformatf("tput%0d instr", i), instr, memword(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      $display("tput %0d: valid=%0d pc=%h instr=%h", i, instr_valid, instr_pc, instr);
      @(negedge clk);
      #1;
    end
`ifdef FETCH_SKID_EN
    chk("tput_count", 32'(nvalid), 32'd10);
`else
    chk("tput_count", 32'(nvalid), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned byte address fetched first after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_addr  output  32  byte address of the current read request; bits [1:0] always 0.
REQ-005 mem_rstrb  output  1  read strobe; memory returns MEM[mem_addr[31:2]] on mem_rdata one cycle later.
REQ-006 mem_rdata  input  32  read data, valid only in the cycle after a mem_rstrb=1 cycle.
REQ-007 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-008 redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-009 instr_valid  output  1  instr/instr_pc hold a fetched word.
REQ-010 instr_ready  input  1  consumer accepts the word when instr_valid & instr_ready.
REQ-011 instr  output  32  fetched instruction word.
REQ-012 instr_pc  output  32  byte address instr was fetched from.

Function
REQ-013 The unit SHALL keep a fetch pc; each request drives mem_addr={pc[31:2],2'b00}, mem_rstrb=1, then pc<=pc+4 (wraps 32'hFFFF_FFFC->0).
REQ-014 Data returned for a request SHALL be presented on instr/instr_pc with instr_valid=1 starting the cycle after the response cycle (request N, response N+1, instr_valid at N+2).
REQ-015 instr, instr_pc and instr_valid SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-016 No response SHALL ever be dropped or duplicated absent a redirect; mem_rstrb SHALL be 0 whenever no storage is free for the response.
REQ-017 Base FSM states: REQ (mem_rstrb=1) -> RESP (capture mem_rdata) -> HOLD while output held and not accepted -> REQ once accepted; throughput one word per 2 cycles with instr_ready=1.
REQ-018 redirect_valid SHALL have priority over all other events: next cycle instr_valid=0, skid empty, any response due that cycle discarded, pc=redirect_pc&~3, FSM in REQ.
REQ-019 A redirect coinciding with instr_valid&instr_ready SHALL count as accepted; with an arriving response SHALL discard the response.
REQ-020 Back-to-back redirects: only the last SHALL take effect.
REQ-021 mem_rstrb SHALL be 0 in the redirect cycle itself.

Reset
REQ-022 While reset=1: mem_rstrb=0, instr_valid=0, instr=32'h0000_0013, instr_pc=0, pc=RESET_PC, skid empty, FSM in REQ.
REQ-023 First request (mem_addr=RESET_PC) SHALL occur in the first cycle with reset=0.
REQ-024 Reset asserted mid-fetch SHALL discard any in-flight response.

Configuration
REQ-025 Macro FETCH_SKID_EN: when defined, requests issue every cycle while the output register or a one-entry skid buffer can absorb the response; a response arriving while output is held goes to the skid and moves to output on acceptance; issue stops when skid full or would fill.
REQ-026 With FETCH_SKID_EN, sustained throughput SHALL be one word per cycle with instr_ready=1; without it, REQ-017 behaviour only, no skid storage.

Structure
REQ-027 Shared package fetch_pkg SHALL hold the FSM state enum, NOP constant 32'h0000_0013 and the default RESET_PC.
REQ-028 The skid buffer SHALL be sub-module fetch_skid_buf (32-bit data + 32-bit pc, valid flag, flush input), instantiated only under FETCH_SKID_EN.

Verification
REQ-029 Reset release, memory preloaded words 0..3, instr_ready=1 -> instr_pc 0,4,8,12 in order with matching instr; first instr_valid 2 cycles after reset release.
REQ-030 instr_ready=0 for 5 cycles after first valid -> instr/instr_pc frozen, mem_rstrb=0 once storage full, no lost word after ready returns.
REQ-031 redirect_valid with redirect_pc=32'h0000_0042 during pending response -> that response dropped, next instr_pc=32'h0000_0040.
REQ-032 Redirect to 32'hFFFF_FFFC -> instr_pc FFFF_FFFC then 0000_0000.
REQ-033 reset pulsed one cycle mid-stream -> instr_valid=0 next cycle, refetch from RESET_PC.
REQ-034 With FETCH_SKID_EN, instr_ready=1 for 10 cycles -> 10 consecutive instr_valid cycles, consecutive instr_pc; without it -> valid every other cycle.
